// File: rtl/sys_retire_pipe.sv
// Retire pipeline for system/CSR instructions: carries issued ops through depth_p
// stages and forms the retire-side CSR write value, instret pulse and scoreboard clears.
module sys_retire_pipe #(
    parameter int vaddr_width_p = 39,
    parameter int dpath_width_p = 64,
    parameter int depth_p       = 2,
    parameter int excp_width_p  = 8,
    parameter int spec_width_p  = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,

    input  logic                     issue_v_i,
    input  logic [vaddr_width_p-1:0] issue_pc_i,
    input  logic [dpath_width_p-1:0] issue_rs1_i,
    input  logic [dpath_width_p-1:0] issue_rs2_i,
    input  logic [dpath_width_p-1:0] issue_imm_i,
    input  logic [31:0]              issue_instr_i,
    input  logic [2:0]               issue_csr_op_i,
    input  logic                     issue_compressed_i,
    input  logic                     issue_score_i,
    input  logic                     issue_irf_w_i,
    input  logic                     issue_frf_w_i,
    input  logic                     issue_spec_w_i,

    input  logic                     stall_i,
    input  logic                     flush_i,

    input  logic                     retire_v_i,
    input  logic                     retire_queue_v_i,
    input  logic [dpath_width_p-1:0] retire_data_i,
    input  logic [excp_width_p-1:0]  retire_exception_i,
    input  logic [spec_width_p-1:0]  retire_special_i,

    output logic                     ret_v_o,
    output logic                     ret_instret_o,
    output logic [vaddr_width_p-1:0] ret_npc_o,
    output logic [dpath_width_p-1:0] ret_vaddr_o,
    output logic [dpath_width_p-1:0] ret_data_o,
    output logic [31:0]              ret_instr_o,
    output logic                     ret_compressed_o,
    output logic [excp_width_p-1:0]  ret_exception_o,
    output logic [spec_width_p-1:0]  ret_special_o,
    output logic                     ret_iscore_o,
    output logic                     ret_fscore_o,

    output logic [63:0]              instret_cnt_o,
    output logic                     tail_v_o,
    output logic                     underflow_o
);

    localparam int tail_lp = depth_p - 1;

    typedef struct packed {
        logic [vaddr_width_p-1:0] pc;
        logic [dpath_width_p-1:0] vaddr;
        logic [dpath_width_p-1:0] rs2;
        logic [31:0]              instr;
        logic [2:0]               csr_op;
        logic                     compressed;
        logic                     iscore;
        logic                     fscore;
        logic                     spec_w;
    } stage_t;

    stage_t                     stage_r [depth_p];
    stage_t                     issue_stage_s;
    stage_t                     tail_s;
    logic [depth_p-1:0]         valid_r;
    logic [depth_p-1:0]         valid_nxt_s;
    logic                       tail_v_s;
    logic [dpath_width_p-1:0]   uimm_s;
    logic [dpath_width_p-1:0]   operand_s;
    logic [dpath_width_p-1:0]   csr_data_s;
    logic                       instret_s;
    logic                       spec_ok_s;
    logic [63:0]                instret_cnt_r;
    logic                       underflow_r;

    // Build the stage-0 payload from the issue port
    always_comb begin
        issue_stage_s            = '0;
        issue_stage_s.pc         = issue_pc_i;
        issue_stage_s.vaddr      = issue_rs1_i + issue_imm_i;
        issue_stage_s.rs2        = issue_rs2_i;
        issue_stage_s.instr      = issue_instr_i;
        issue_stage_s.csr_op     = issue_csr_op_i;
        issue_stage_s.compressed = issue_compressed_i;
        issue_stage_s.iscore     = issue_score_i & issue_irf_w_i;
        issue_stage_s.fscore     = issue_score_i & issue_frf_w_i;
        issue_stage_s.spec_w     = issue_score_i & issue_spec_w_i;
    end

    // Payload shift register; payload carries no reset, validity lives in valid_r
    always_ff @(posedge clk_i) begin
        if (!stall_i) begin
            stage_r[0] <= issue_stage_s;
            for (int k = 1; k < depth_p; k++) begin
                stage_r[k] <= stage_r[k-1];
            end
        end
    end

    // Next valid bits: flush kills everything younger than the tail even under stall
    always_comb begin
        valid_nxt_s = valid_r;
        if (stall_i) begin
            for (int k = 0; k < depth_p - 1; k++) begin
                if (flush_i) begin
                    valid_nxt_s[k] = 1'b0;
                end else begin
                    valid_nxt_s[k] = valid_r[k];
                end
            end
        end else begin
            valid_nxt_s[0] = issue_v_i & ~flush_i;
            for (int k = 1; k < depth_p; k++) begin
                valid_nxt_s[k] = valid_r[k-1] & ~(flush_i & (k < depth_p - 1));
            end
        end
    end

    // Valid bit register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid_r <= '0;
        end else begin
            valid_r <= valid_nxt_s;
        end
    end

    assign tail_s   = stage_r[tail_lp];
    assign tail_v_s = valid_r[tail_lp];

    // CSR write value: immediate forms substitute the zero-extended rs1 field
    always_comb begin
        uimm_s    = {{(dpath_width_p-5){1'b0}}, tail_s.instr[19:15]};
        operand_s = tail_s.csr_op[2] ? uimm_s : tail_s.vaddr;
        csr_data_s = retire_data_i;
        if (retire_queue_v_i) begin
            case (tail_s.csr_op[1:0])
                2'd1:    csr_data_s = operand_s;
                2'd2:    csr_data_s = operand_s | retire_data_i;
                2'd3:    csr_data_s = ~operand_s & retire_data_i;
                default: csr_data_s = retire_data_i;
            endcase
        end else begin
            csr_data_s = retire_data_i;
        end
    end

    assign instret_s = retire_v_i & retire_queue_v_i & ~(|retire_exception_i) & tail_v_s;
    assign spec_ok_s = ~tail_s.spec_w | (|retire_special_i);

    assign ret_v_o          = retire_v_i;
    assign ret_instret_o    = instret_s;
    assign ret_npc_o        = tail_s.pc;
    assign ret_vaddr_o      = tail_s.vaddr;
    assign ret_data_o       = csr_data_s;
    assign ret_instr_o      = tail_s.instr;
    assign ret_compressed_o = tail_s.compressed;
    assign ret_exception_o  = retire_v_i ? retire_exception_i : {excp_width_p{1'b0}};
    assign ret_special_o    = instret_s ? retire_special_i : {spec_width_p{1'b0}};
    assign ret_iscore_o     = instret_s & tail_s.iscore & spec_ok_s;
    assign ret_fscore_o     = instret_s & tail_s.fscore & spec_ok_s;
    assign tail_v_o         = tail_v_s;
    assign instret_cnt_o    = instret_cnt_r;
    assign underflow_o      = underflow_r;

    // Retired-instruction counter and sticky retire-on-empty flag
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            instret_cnt_r <= 64'd0;
            underflow_r   <= 1'b0;
        end else begin
            if (instret_s) begin
                instret_cnt_r <= instret_cnt_r + 64'd1;
            end
            if (retire_v_i && !tail_v_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sys_retire_pipe.sv
// Scoreboard bench for sys_retire_pipe: a queue-of-instructions model predicts each
// retire response; a monitor compares whenever ret_v_o is presented.
module tb_sys_retire_pipe;
    localparam int VA = 39, DW = 64, DEPTH = 2, EW = 8, SW = 8;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic reset_n_i;
    logic issue_v_i, issue_compressed_i, issue_score_i, issue_irf_w_i, issue_frf_w_i, issue_spec_w_i;
    logic [VA-1:0] issue_pc_i;
    logic [DW-1:0] issue_rs1_i, issue_rs2_i, issue_imm_i, retire_data_i;
    logic [31:0] issue_instr_i;
    logic [2:0] issue_csr_op_i;
    logic stall_i, flush_i, retire_v_i, retire_queue_v_i;
    logic [EW-1:0] retire_exception_i;
    logic [SW-1:0] retire_special_i;
    logic ret_v_o, ret_instret_o, ret_compressed_o, ret_iscore_o, ret_fscore_o, tail_v_o, underflow_o;
    logic [VA-1:0] ret_npc_o;
    logic [DW-1:0] ret_vaddr_o, ret_data_o;
    logic [31:0] ret_instr_o;
    logic [EW-1:0] ret_exception_o;
    logic [SW-1:0] ret_special_o;
    logic [63:0] instret_cnt_o;

    sys_retire_pipe #(.vaddr_width_p(VA), .dpath_width_p(DW), .depth_p(DEPTH),
                      .excp_width_p(EW), .spec_width_p(SW)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .issue_v_i(issue_v_i), .issue_pc_i(issue_pc_i), .issue_rs1_i(issue_rs1_i),
        .issue_rs2_i(issue_rs2_i), .issue_imm_i(issue_imm_i), .issue_instr_i(issue_instr_i),
        .issue_csr_op_i(issue_csr_op_i), .issue_compressed_i(issue_compressed_i),
        .issue_score_i(issue_score_i), .issue_irf_w_i(issue_irf_w_i),
        .issue_frf_w_i(issue_frf_w_i), .issue_spec_w_i(issue_spec_w_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .retire_v_i(retire_v_i), .retire_queue_v_i(retire_queue_v_i),
        .retire_data_i(retire_data_i), .retire_exception_i(retire_exception_i),
        .retire_special_i(retire_special_i),
        .ret_v_o(ret_v_o), .ret_instret_o(ret_instret_o), .ret_npc_o(ret_npc_o),
        .ret_vaddr_o(ret_vaddr_o), .ret_data_o(ret_data_o), .ret_instr_o(ret_instr_o),
        .ret_compressed_o(ret_compressed_o), .ret_exception_o(ret_exception_o),
        .ret_special_o(ret_special_o), .ret_iscore_o(ret_iscore_o), .ret_fscore_o(ret_fscore_o),
        .instret_cnt_o(instret_cnt_o), .tail_v_o(tail_v_o), .underflow_o(underflow_o)
    );

    // An in-flight instruction; age = number of clock edges it has advanced through
    typedef struct {
        int            age;
        logic [VA-1:0] pc;
        logic [DW-1:0] vaddr;
        logic [31:0]   instr;
        logic [2:0]    op;
        logic          c, isc, fsc, spw;
    } ent_t;

    typedef struct {
        logic          tv;
        logic [VA-1:0] npc;
        logic [DW-1:0] vaddr, data;
        logic [31:0]   instr;
        logic          c, instret, isc, fsc, uf;
        logic [EW-1:0] exc;
        logic [SW-1:0] spec;
        logic [63:0]   cnt;
    } exp_t;

    ent_t pipe_q[$];
    exp_t sb_q[$];
    logic [63:0] m_cnt;
    logic m_uf;
    int n_checks = 0;
    int n_err = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // CSR semantics: write / set bits / clear bits, operand is rs1+imm or the 5-bit uimm
    function automatic logic [DW-1:0] csr_result(ent_t e, logic qv, logic [DW-1:0] old);
        logic [DW-1:0] opnd;
        opnd = e.op[2] ? DW'(e.instr[19:15]) : e.vaddr;
        if (!qv) return old;
        case (e.op)
            3'd1, 3'd5: return opnd;
            3'd2, 3'd6: return opnd | old;
            3'd3, 3'd7: return ~opnd & old;
            default:    return old;
        endcase
    endfunction

    // Predict this cycle's retire response from the pre-edge model, then advance it
    task automatic model_cycle();
        int ti;
        ent_t t;
        exp_t x;
        ent_t nq[$];
        if (!reset_n_i) begin
            pipe_q.delete();
            m_cnt = 64'd0;
            m_uf  = 1'b0;
        end
        ti = -1;
        foreach (pipe_q[i]) if (pipe_q[i].age == DEPTH) ti = i;
        t = '{default: 0};
        x.tv = (ti >= 0);
        if (x.tv) t = pipe_q[ti];
        x.instret = retire_v_i & retire_queue_v_i & (retire_exception_i == '0) & x.tv;
        x.npc   = t.pc;
        x.vaddr = t.vaddr;
        x.instr = t.instr;
        x.c     = t.c;
        x.data  = csr_result(t, retire_queue_v_i, retire_data_i);
        x.exc   = retire_v_i ? retire_exception_i : '0;
        x.spec  = x.instret ? retire_special_i : '0;
        x.isc   = x.instret & t.isc & (~t.spw | (retire_special_i != '0));
        x.fsc   = x.instret & t.fsc & (~t.spw | (retire_special_i != '0));
        x.cnt   = m_cnt;
        x.uf    = m_uf;
        if (retire_v_i) sb_q.push_back(x);
        if (reset_n_i) begin
            if (x.instret) m_cnt = m_cnt + 64'd1;
            if (retire_v_i && !x.tv) m_uf = 1'b1;
            foreach (pipe_q[i]) if (!stall_i) pipe_q[i].age++;
            foreach (pipe_q[i])
                if (pipe_q[i].age <= DEPTH && !(flush_i && pipe_q[i].age < DEPTH))
                    nq.push_back(pipe_q[i]);
            pipe_q = nq;
            if (!stall_i && !flush_i && issue_v_i) begin
                t.age = 1; t.pc = issue_pc_i; t.vaddr = issue_rs1_i + issue_imm_i;
                t.instr = issue_instr_i; t.op = issue_csr_op_i; t.c = issue_compressed_i;
                t.isc = issue_score_i & issue_irf_w_i;
                t.fsc = issue_score_i & issue_frf_w_i;
                t.spw = issue_score_i & issue_spec_w_i;
                pipe_q.push_back(t);
            end
        end
    endtask

    // Monitor: every presented retire is compared against the oldest prediction
    always @(negedge clk_i) begin : monitor
        exp_t x;
        #2;
        if (ret_v_o) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_retire", 64'd1, 64'd0);
            end else begin
                x = sb_q.pop_front();
                chk("tail_v", 64'(tail_v_o), 64'(x.tv));
                chk("instret", 64'(ret_instret_o), 64'(x.instret));
                chk("exception", 64'(ret_exception_o), 64'(x.exc));
                chk("special", 64'(ret_special_o), 64'(x.spec));
                chk("iscore", 64'(ret_iscore_o), 64'(x.isc));
                chk("fscore", 64'(ret_fscore_o), 64'(x.fsc));
                chk("instret_cnt", instret_cnt_o, x.cnt);
                chk("underflow", 64'(underflow_o), 64'(x.uf));
                if (x.tv) begin
                    chk("npc", 64'(ret_npc_o), 64'(x.npc));
                    chk("vaddr", ret_vaddr_o, x.vaddr);
                    chk("instr", 64'(ret_instr_o), 64'(x.instr));
                    chk("compressed", 64'(ret_compressed_o), 64'(x.c));
                    chk("data", ret_data_o, x.data);
                end
            end
        end
    end

    task automatic idle();
        issue_v_i = 1'b0; issue_pc_i = '0; issue_rs1_i = '0; issue_rs2_i = '0; issue_imm_i = '0;
        issue_instr_i = 32'd0; issue_csr_op_i = 3'd0; issue_compressed_i = 1'b0;
        issue_score_i = 1'b0; issue_irf_w_i = 1'b0; issue_frf_w_i = 1'b0; issue_spec_w_i = 1'b0;
        stall_i = 1'b0; flush_i = 1'b0; retire_v_i = 1'b0; retire_queue_v_i = 1'b0;
        retire_data_i = '0; retire_exception_i = '0; retire_special_i = '0;
    endtask

    task automatic nxt();
        @(negedge clk_i);
        idle();
    endtask

    task automatic iss(logic [2:0] op, logic [DW-1:0] rs1, logic [DW-1:0] imm, logic [31:0] instr,
                       logic sc, logic irf, logic spw);
        issue_v_i = 1'b1; issue_csr_op_i = op; issue_rs1_i = rs1; issue_imm_i = imm;
        issue_instr_i = instr; issue_score_i = sc; issue_irf_w_i = irf; issue_spec_w_i = spw;
        issue_pc_i = VA'({$urandom, $urandom});
        issue_rs2_i = {$urandom, $urandom};
    endtask

    task automatic ret(logic [DW-1:0] data, logic [EW-1:0] exc, logic [SW-1:0] spc);
        retire_v_i = 1'b1; retire_queue_v_i = 1'b1;
        retire_data_i = data; retire_exception_i = exc; retire_special_i = spc;
    endtask

    logic [VA-1:0] pc_a;

    initial begin
        reset_n_i = 1'b0;
        idle();
        m_cnt = 64'd0;
        m_uf = 1'b0;
        // In reset: outputs quiet, exception still passes through with retire_v_i
        nxt(); ret(64'h0, 8'h04, 8'hFF); model_cycle();
        #3 chk("rst_tail_v", 64'(tail_v_o), 64'd0);
        chk("rst_instret", 64'(ret_instret_o), 64'd0);
        chk("rst_special", 64'(ret_special_o), 64'd0);
        nxt(); model_cycle();
        #3 chk("rst_exc_idle", 64'(ret_exception_o), 64'd0);
        chk("rst_cnt", instret_cnt_o, 64'd0);
        // CSRRS: 0x0F | 0xF0
        nxt(); reset_n_i = 1'b1; iss(3'd2, 64'h0F, 64'h0, 32'h30002573, 1'b0, 1'b0, 1'b0); model_cycle();
        nxt(); model_cycle();
        nxt(); ret(64'hF0, 8'h00, 8'h00); model_cycle();
        #3 chk("csrrs_data", ret_data_o, 64'hFF);
        chk("csrrs_instret", 64'(ret_instret_o), 64'd1);
        // CSRRCI uimm=3 clears bits of 0xFF
        nxt(); iss(3'd7, 64'h0, 64'h0, {12'h300, 5'h03, 3'b111, 5'h00, 7'h73}, 1'b0, 1'b0, 1'b0);
        model_cycle();
        #3 chk("cnt_after_csrrs", instret_cnt_o, 64'd1);
        nxt(); model_cycle();
        nxt(); ret(64'hFF, 8'h00, 8'h00); model_cycle();
        #3 chk("csrrci_data", ret_data_o, 64'hFC);
        // Flush one cycle after an issue: older op still reaches the tail
        nxt(); iss(3'd1, 64'h5, 64'h0, 32'h30029073, 1'b0, 1'b0, 1'b0); pc_a = issue_pc_i; model_cycle();
        nxt(); iss(3'd1, 64'h6, 64'h0, 32'h30031073, 1'b0, 1'b0, 1'b0); flush_i = 1'b1; model_cycle();
        nxt(); ret(64'h0, 8'h00, 8'h00); model_cycle();
        #3 chk("flush_old_npc", 64'(ret_npc_o), 64'(pc_a));
        chk("flush_old_tail_v", 64'(tail_v_o), 64'd1);
        nxt(); model_cycle();
        #3 chk("flush_young_gone", 64'(tail_v_o), 64'd0);
        // Exception blocks instret and special
        nxt(); iss(3'd0, 64'h0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0); model_cycle();
        nxt(); model_cycle();
        nxt(); ret(64'h0, 8'h04, 8'h5A); model_cycle();
        #3 chk("exc_instret", 64'(ret_instret_o), 64'd0);
        chk("exc_special", 64'(ret_special_o), 64'd0);
        chk("exc_out", 64'(ret_exception_o), 64'h04);
        nxt(); model_cycle();
        #3 chk("exc_cnt_held", instret_cnt_o, 64'd3);
        // Speculative writer scoreboard clear gated by retire_special_i
        nxt(); iss(3'd0, 64'h0, 64'h0, 32'h0, 1'b1, 1'b1, 1'b1); model_cycle();
        nxt(); iss(3'd0, 64'h0, 64'h0, 32'h0, 1'b1, 1'b1, 1'b1); model_cycle();
        nxt(); ret(64'h0, 8'h00, 8'h00); model_cycle();
        #3 chk("spec_iscore0", 64'(ret_iscore_o), 64'd0);
        nxt(); ret(64'h0, 8'h00, 8'h01); model_cycle();
        #3 chk("spec_iscore1", 64'(ret_iscore_o), 64'd1);
        // Retire on an empty tail sets sticky underflow
        nxt(); ret(64'h0, 8'h00, 8'h00); model_cycle();
        nxt(); ret(64'h0, 8'h00, 8'h00); model_cycle();
        #3 chk("underflow_set", 64'(underflow_o), 64'd1);
        chk("underflow_no_count", instret_cnt_o, 64'd5);
        nxt(); model_cycle();
        #3 chk("underflow_sticky", 64'(underflow_o), 64'd1);
        // Counter wrap from all-ones
        nxt(); iss(3'd1, 64'h9, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0); model_cycle();
        nxt(); model_cycle();
        @(negedge clk_i);
        idle();
        force dut.instret_cnt_r = 64'hFFFF_FFFF_FFFF_FFFF;
        #1 release dut.instret_cnt_r;
        m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        ret(64'h0, 8'h00, 8'h00); model_cycle();
        #2 chk("cnt_preset", instret_cnt_o, 64'hFFFF_FFFF_FFFF_FFFF);
        nxt(); model_cycle();
        #3 chk("cnt_wrap", instret_cnt_o, 64'd0);
        // Randomized traffic with occasional mid-flight reset
        for (int c = 0; c < 3000; c++) begin
            nxt();
            reset_n_i = ($urandom_range(0, 299) != 0);
            issue_v_i = ($urandom_range(0, 3) != 0);
            issue_pc_i = VA'({$urandom, $urandom});
            issue_rs1_i = {$urandom, $urandom};
            issue_rs2_i = {$urandom, $urandom};
            issue_imm_i = {$urandom, $urandom};
            issue_instr_i = $urandom;
            issue_csr_op_i = 3'($urandom_range(0, 7));
            issue_compressed_i = 1'($urandom_range(0, 1));
            issue_score_i = 1'($urandom_range(0, 1));
            issue_irf_w_i = 1'($urandom_range(0, 1));
            issue_frf_w_i = 1'($urandom_range(0, 1));
            issue_spec_w_i = 1'($urandom_range(0, 1));
            stall_i = ($urandom_range(0, 4) == 0);
            flush_i = ($urandom_range(0, 7) == 0);
            retire_v_i = ($urandom_range(0, 3) != 0);
            retire_queue_v_i = ($urandom_range(0, 3) != 0);
            retire_data_i = {$urandom, $urandom};
            retire_exception_i = ($urandom_range(0, 3) == 0) ? EW'($urandom) : '0;
            retire_special_i = ($urandom_range(0, 1) == 0) ? SW'($urandom) : '0;
            model_cycle();
        end
        nxt(); reset_n_i = 1'b1; model_cycle();
        nxt(); model_cycle();
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
